// File: rtl/flat_to_2d_array_deserializer_if.sv
// Stream-in / frame-out bundle for flat_to_2d_array_deserializer.
// The slave modport is the deserializer; the master modport is the producer/consumer side.
interface flat_to_2d_array_deserializer_if #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int LANES     = 2
);
    logic [LANES*BIT_WIDTH-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [BIT_WIDTH-1:0]       out [ROWS][COLS];
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/flat_to_2d_array_deserializer.sv
// Rebuilds a column-major ROWS x COLS frame from a LANES-wide valid/ready stream.
// Optional feature macro DOUBLE_BUFFER_EN: ping-pong banks for full-rate back-to-back frames.
module flat_to_2d_array_deserializer #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int LANES     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    flat_to_2d_array_deserializer_if.slave   bus
);
    localparam int BEATS = (ROWS * COLS) / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (((ROWS * COLS) % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide ROWS*COLS");
    end

    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept_s;
    logic             last_s;
    logic             take_s;
    logic             load_s;

    assign accept_s      = bus.in_valid & in_ready_q;
    assign last_s        = accept_s & (beat_cnt_q == LAST_BEAT);
    assign take_s        = bus.out_ready & out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;

    // Beat counter next state: wraps to zero after the final beat of a frame.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept_s) begin
            if (last_s) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       fill_ptr_q;
    logic       rd_ptr_q;
    logic       rd_ptr_d;

    // Occupancy: a completion and a handshake in the same cycle cancel out.
    always_comb begin
        occ_d = occ_q;
        if (last_s && !take_s) begin
            occ_d = occ_q + 2'd1;
        end else if (take_s && !last_s) begin
            occ_d = occ_q - 2'd1;
        end else begin
            occ_d = occ_q;
        end
    end

    assign rd_ptr_d = rd_ptr_q ^ take_s;
    assign load_s   = (occ_d != 2'd0) && (take_s || (occ_q == 2'd0));

    // Control for the ping-pong pair; handshake flags are registered from next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            occ_q       <= 2'd0;
            fill_ptr_q  <= 1'b0;
            rd_ptr_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            occ_q       <= occ_d;
            fill_ptr_q  <= fill_ptr_q ^ last_s;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= (occ_d != 2'd2);
            out_valid_q <= (occ_d != 2'd0);
        end
    end
`else
    typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_e;
    state_e state_q;

    assign load_s = last_s;

    // FILL/HOLD sequencer; in_ready returns one cycle after the frame is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            beat_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    beat_cnt_q <= beat_cnt_d;
                    if (last_s) begin
                        state_q     <= HOLD;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (take_s) begin
                        state_q     <= FILL;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= FILL;
                    beat_cnt_q  <= '0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K    = c * ROWS + r;
            localparam int LANE = K % LANES;
            localparam logic [CNT_W-1:0] BEAT = CNT_W'(K / LANES);

            logic                 hit_s;
            logic [BIT_WIDTH-1:0] lane_s;
            logic [BIT_WIDTH-1:0] out_q;

            assign hit_s  = accept_s & (beat_cnt_q == BEAT);
            assign lane_s = bus.in_data[LANE*BIT_WIDTH +: BIT_WIDTH];
`ifdef DOUBLE_BUFFER_EN
            logic [BIT_WIDTH-1:0] bank0_q, bank1_q, bank0_d, bank1_d;
            assign bank0_d = (hit_s & ~fill_ptr_q) ? lane_s : bank0_q;
            assign bank1_d = (hit_s &  fill_ptr_q) ? lane_s : bank1_q;

            // Element storage in both banks; out copies the oldest complete bank.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bank0_q <= '0;
                    bank1_q <= '0;
                    out_q   <= '0;
                end else begin
                    bank0_q <= bank0_d;
                    bank1_q <= bank1_d;
                    if (load_s) begin
                        out_q <= rd_ptr_d ? bank1_d : bank0_d;
                    end
                end
            end
`else
            logic [BIT_WIDTH-1:0] fill_q, fill_d;
            assign fill_d = hit_s ? lane_s : fill_q;

            // Fill element plus its holding copy, loaded when the frame completes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fill_q <= '0;
                    out_q  <= '0;
                end else begin
                    fill_q <= fill_d;
                    if (load_s) begin
                        out_q <= fill_d;
                    end
                end
            end
`endif
            assign bus.out[r][c] = out_q;
        end
    end
endmodule
